// File: rtl/emmc_lane_framer_if.sv
// emmc_lane_framer_if: CMD/DAT byte streams plus serializer-side lane signals of the framer.
interface emmc_lane_framer_if;
   logic cmd_valid, cmd_last, cmd_ready;
   logic [7:0] cmd_byte;
   logic dat_valid, dat_last, dat_ready;
   logic [7:0] dat_byte;
   logic tx_ready;
   logic [7:0] tx_word;
   logic [1:0] grant;
   logic [15:0] frame_cnt;
   logic [7:0] trunc_cnt;
   modport master(
      output cmd_valid, cmd_byte, cmd_last, dat_valid, dat_byte, dat_last, tx_ready,
      input cmd_ready, dat_ready, tx_word, grant, frame_cnt, trunc_cnt
   );
   modport slave(
      input cmd_valid, cmd_byte, cmd_last, dat_valid, dat_byte, dat_last, tx_ready,
      output cmd_ready, dat_ready, tx_word, grant, frame_cnt, trunc_cnt
   );
endinterface

// File: rtl/emmc_lane_framer.sv
// emmc_lane_framer: arbitrates CMD and DAT byte streams onto one TX lane as header/payload/XOR-trailer frames.
module emmc_lane_framer #(
   parameter logic [7:0] IDLE_WORD = 8'hBC,
   parameter logic [7:0] HDR_CMD = 8'hC5,
   parameter logic [7:0] HDR_DAT = 8'hD5,
   parameter int CMD_MAX = 8,
   parameter int DAT_MAX = 16
) (
   input logic clk_div,
   input logic rst,
   emmc_lane_framer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, TRAIL} state_t;
   state_t state, state_n;
   logic [1:0] grant_n;
   logic [7:0] word_n, chk, cnt, cap, in_byte;
   logic last_dat, is_cmd, in_valid, in_last, acc, at_cap, pick_cmd;
   always_comb begin
      is_cmd = bus.grant[0];
      in_valid = is_cmd ? bus.cmd_valid : bus.dat_valid;
      in_last = is_cmd ? bus.cmd_last : bus.dat_last;
      in_byte = is_cmd ? bus.cmd_byte : bus.dat_byte;
      cap = is_cmd ? 8'(CMD_MAX) : 8'(DAT_MAX);
      at_cap = cnt + 8'd1 == cap;
      acc = state == PAYLOAD && in_valid;
      bus.cmd_ready = state == PAYLOAD && bus.grant[0] && bus.tx_ready;
      bus.dat_ready = state == PAYLOAD && bus.grant[1] && bus.tx_ready;
      // on a tie the channel that did not own the previous frame wins
      pick_cmd = bus.cmd_valid && (!bus.dat_valid || last_dat);
      state_n = state;
      grant_n = bus.grant;
      word_n = IDLE_WORD;
      case (state)
         IDLE: begin
            grant_n = pick_cmd ? 2'b01 : bus.dat_valid ? 2'b10 : 2'b00;
            state_n = bus.cmd_valid || bus.dat_valid ? HDR : IDLE;
         end
         HDR: begin
            word_n = is_cmd ? HDR_CMD : HDR_DAT;
            state_n = PAYLOAD;
         end
         PAYLOAD: begin
            word_n = in_valid ? in_byte : IDLE_WORD;
            state_n = in_valid && (in_last || at_cap) ? TRAIL : PAYLOAD;
         end
         default: begin
            word_n = chk;
            grant_n = 2'b00;
            state_n = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk_div) begin
      if (rst) begin
         state <= IDLE;
         bus.grant <= 2'b00;
         bus.tx_word <= IDLE_WORD;
         bus.frame_cnt <= 16'd0;
         bus.trunc_cnt <= 8'd0;
         last_dat <= 1'b1;
         chk <= 8'd0;
         cnt <= 8'd0;
      end else if (bus.tx_ready) begin
         state <= state_n;
         bus.grant <= grant_n;
         bus.tx_word <= word_n;
         if (state == HDR) begin
            chk <= 8'd0;
            cnt <= 8'd0;
         end
         if (acc) begin
            chk <= chk ^ in_byte;
            cnt <= cnt + 8'd1;
         end
         if (acc && at_cap && !in_last && bus.trunc_cnt != 8'hFF) bus.trunc_cnt <= bus.trunc_cnt + 8'd1;
         if (state == TRAIL) begin
            bus.frame_cnt <= bus.frame_cnt + 16'd1;
            last_dat <= bus.grant[1];
         end
      end
   end
endmodule
